// File: rtl/pm_pkg.sv
// Shared definitions for the sequential multiply/divide datapath blocks:
// state encoding, default operand width and a magnitude helper.
package pm_pkg;

  localparam int DEF_WIDTH = 32;

  // All four 2-bit codes are assigned, so there is no unreachable encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Magnitude of a two's-complement value when sgn is set, raw value otherwise.
  // -2^(W-1) maps onto itself, which is exactly its unsigned magnitude.
  function automatic logic [DEF_WIDTH-1:0] abs_w(input logic [DEF_WIDTH-1:0] v,
                                                 input logic                 sgn);
    return (sgn && v[DEF_WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/sdiv32_div_step.sv
// One restoring-division step: shift {rem,quo} left by one, try to subtract
// the divisor from the partial remainder and record the outcome as the new
// quotient bit.
module div_step
  import pm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  // The shifted remainder is < 2*div, so it needs one extra bit; the trial
  // carries one more bit again so its MSB is a clean borrow flag.
  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] trial;

  assign sh    = {rem, quo[WIDTH-1]};
  assign trial = {1'b0, sh} - {2'b00, div};

  // Keep the difference when it did not borrow, otherwise restore.
  always_comb begin
    // NOTE: every output gets a value on every path, so no latch is inferred.
    rem_nxt = sh[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH+1]) begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/sdiv32.sv
// Sequential 32/32 restoring divider, signed or unsigned, with start/done
// handshake. Quotient and remainder are registered and only change in FIX.
// Optional feature macro SDIV_DZ_FAST_EN: adds the dz port and lets a zero
// divisor skip the RUN phase.
module sdiv32
  import pm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done
`ifdef SDIV_DZ_FAST_EN
  ,
  output logic             dz
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] div;
  logic [WIDTH-1:0] dvd_raw;
  logic             neg_q;
  logic             neg_r;
  logic             dvs_zero;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .quo     (quo),
    .div     (div),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  // Control FSM, iteration counter, operand capture and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every register here is small control/datapath state, so all of
      // it is reset; an abort mid-operation leaves no stale result behind.
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      div      <= '0;
      dvd_raw  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dvs_zero <= 1'b0;
      q        <= '0;
      r        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef SDIV_DZ_FAST_EN
      dz       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      case (state)
        IDLE, DONE: begin
          if (start) begin
            quo      <= abs_w(dvd, sgn);
            div      <= abs_w(dvs, sgn);
            dvd_raw  <= dvd;
            rem      <= '0;
            cnt      <= '0;
            neg_q    <= sgn & (dvd[WIDTH-1] ^ dvs[WIDTH-1]);
            neg_r    <= sgn & dvd[WIDTH-1];
            dvs_zero <= (dvs == '0);
            busy     <= 1'b1;
            done     <= 1'b0;
`ifdef SDIV_DZ_FAST_EN
            dz       <= 1'b0;
            state    <= (dvs == '0) ? FIX : RUN;
`else
            state    <= RUN;
`endif
          end
        end
        RUN: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (dvs_zero) begin
            q <= '1;
            r <= dvd_raw;
          end else begin
            q <= neg_q ? (~quo + 1'b1) : quo;
            r <= neg_r ? (~rem + 1'b1) : rem;
          end
`ifdef SDIV_DZ_FAST_EN
          dz    <= dvs_zero;
`endif
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdiv32.sv
// Self-checking bench for sdiv32: directed corner cases plus randomized
// operands compared against a plain-arithmetic reference model.
module tb_sdiv32;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        done;
`ifdef SDIV_DZ_FAST_EN
  logic        dz;
`endif

  int errors = 0;
  int checks = 0;

  sdiv32 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sgn   (sgn),
    .dvd   (dvd),
    .dvs   (dvs),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done)
`ifdef SDIV_DZ_FAST_EN
    ,
    .dz    (dz)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero when signed;
  // a zero divisor yields all ones and the dividend unchanged.
  task automatic ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eq, output logic [31:0] er);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF;
      er = a;
    end else begin
      sa = s ? longint'($signed(a)) : longint'({32'd0, a});
      sb = s ? longint'($signed(b)) : longint'({32'd0, b});
      eq = 32'(sa / sb);
      er = 32'(sa % sb);
    end
  endtask

  // Launch one division; lat counts edges from the start-sampling edge (=1)
  // until done is seen. Optionally re-pulse start with junk after glitch_at edges.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input int glitch_at,
                       output int lat, output int bcyc,
                       output logic d1, output logic [31:0] q1);
    @(negedge clk);
    sgn = s; dvd = a; dvs = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; bcyc = 0;
    d1 = done; q1 = q;
    if (busy) bcyc++;
    while (!done && lat < 100) begin
      if (lat == glitch_at) begin
        sgn = ~s; dvd = 32'd999; dvs = 32'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (busy) bcyc++;
    end
    start = 1'b0;
    if (!done) check("timeout_done", 32'(done), 32'd1);
  endtask

  task automatic run_check(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat);
    int lat, bc;
    logic d1;
    logic [31:0] q1, eq, er;
    ref_div(s, a, b, eq, er);
    do_op(s, a, b, 0, lat, bc, d1, q1);
    check({tag, "_q"}, q, eq);
    check({tag, "_r"}, r, er);
    if (exp_lat > 0) check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int lat, bc;
    logic d1;
    logic [31:0] q1, a, b, eq, er, oldq;
    logic s;
    int kind;

    rst = 1'b1; start = 1'b0; sgn = 1'b0; dvd = '0; dvs = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", q, 32'd0);
    check("rst_r", r, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Unsigned 100/7 with latency and busy length.
    do_op(1'b0, 32'd100, 32'd7, 0, lat, bc, d1, q1);
    check("u100_7_q", q, 32'd14);
    check("u100_7_r", r, 32'd2);
    check("u100_7_lat", 32'(lat), 32'd34);
    check("u100_7_busy", 32'(bc), 32'd33);

    // Signed cases and the overflow corner.
    run_check("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 34);
    check("s_m7_2_qk", q, 32'hFFFF_FFFD);
    check("s_m7_2_rk", r, 32'hFFFF_FFFF);
    run_check("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 34);
    check("s_7_m2_rk", r, 32'd1);
    run_check("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34);
    check("s_ovf_qk", q, 32'h8000_0000);
    run_check("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 34);
    check("u_ovf_rk", r, 32'h8000_0000);

    // Divide by zero.
`ifdef SDIV_DZ_FAST_EN
    run_check("dz5", 1'b0, 32'd5, 32'd0, 2);
    check("dz_flag", 32'(dz), 32'd1);
    run_check("dzs", 1'b1, 32'hFFFF_FFFB, 32'd0, 2);
    run_check("after_dz", 1'b0, 32'd9, 32'd4, 34);
    check("dz_clear", 32'(dz), 32'd0);
`else
    run_check("dz5", 1'b0, 32'd5, 32'd0, 34);
    run_check("dzs", 1'b1, 32'hFFFF_FFFB, 32'd0, 34);
`endif

    // Start during RUN must be ignored.
    do_op(1'b0, 32'd100, 32'd7, 5, lat, bc, d1, q1);
    check("glitch_q", q, 32'd14);
    check("glitch_r", r, 32'd2);
    check("glitch_lat", 32'(lat), 32'd34);

    // Back-to-back: start in DONE drops done, keeps old q until FIX.
    oldq = q;
    do_op(1'b0, 32'd1000, 32'd10, 0, lat, bc, d1, q1);
    check("b2b_done_drop", 32'(d1), 32'd0);
    check("b2b_q_hold", q1, oldq);
    check("b2b_q", q, 32'd100);
    check("b2b_lat", 32'(lat), 32'd34);

    // Asynchronous reset at cnt==10 aborts the operation.
    @(negedge clk);
    sgn = 1'b0; dvd = 32'd77; dvs = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_q", q, 32'd0);
    check("abort_r", r, 32'd0);
    @(negedge clk) rst = 1'b0;
    run_check("post_abort", 1'b0, 32'd77, 32'd5, 34);

    // Randomized operands, both signednesses.
    for (int i = 0; i < 1000; i++) begin
      kind = int'($urandom_range(0, 19));
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case (kind)
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2, 3, 4, 5, 6, 7: b = 32'($urandom_range(1, 15));
        8, 9, 10, 11:     b = 32'(-int'($urandom_range(1, 15)));
        12, 13:  b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if (b == 32'd0 && kind != 0) b = 32'd1;
      ref_div(s, a, b, eq, er);
      do_op(s, a, b, 0, lat, bc, d1, q1);
      check("rnd_q", q, eq);
      check("rnd_r", r, er);
      check("rnd_ident", q * b + r, a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
